// File: rtl/frame_scanout_pkg.sv
// Shared definitions for the frame scanout block:
// FSM encoding, RGB565 field layout and RGB888 expansion.
package frame_scanout_pkg;

  localparam logic [1:0] ST_WAIT_SRC  = 2'd0;
  localparam logic [1:0] ST_WAIT_DISP = 2'd1;
  localparam logic [1:0] ST_RUN       = 2'd2;

  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Replicate MSBs into the new LSBs so full-scale maps to 8'hFF.
  function automatic rgb888_t expand565(input logic [15:0] p);
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;
    rgb888_t    o;
    r5  = p[R_MSB:R_LSB];
    g6  = p[G_MSB:G_LSB];
    b5  = p[B_MSB:B_LSB];
    o.r = {r5, r5[4:2]};
    o.g = {g6, g6[5:4]};
    o.b = {b5, b5[4:2]};
    return o;
  endfunction

endpackage

// File: rtl/scanout_fifo.sv
// Synchronous FIFO with registered read data and a
// single-cycle flush that empties it.
module scanout_fifo #(
  parameter int AW = 6,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem_q [2**AW];
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   rd_ptr_q;
  logic [DW-1:0] rd_data_q;
  logic          do_wr;
  logic          do_rd;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = rd_data_q;

  // Flush wins over a same-cycle write: the word is dropped.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else if (do_rd) rd_data_q <= mem_q[rd_ptr_q[AW-1:0]];
  end

endmodule

// File: rtl/frame_scanout.sv
// Frame-locked scanout: buffers RGB565 words and releases
// them as RGB888 under the video timing generator's DE.
module frame_scanout
  import frame_scanout_pkg::*;
#(
  parameter int H_DISP  = 32,
  parameter int V_DISP  = 24,
  parameter int FIFO_AW = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  input  logic        in_vs,
  output logic        in_ready,
  input  logic        vid_de,
  input  logic        vid_hs,
  input  logic        vid_vs,
  output logic        out_de,
  output logic        out_hs,
  output logic        out_vs,
  output logic [7:0]  out_r,
  output logic [7:0]  out_g,
  output logic [7:0]  out_b,
  output logic        underflow,
  output logic        locked
);

  localparam int FRAME = H_DISP * V_DISP;
  localparam int CW    = $clog2(FRAME + 1);
  localparam logic [CW-1:0] FRAME_C = CW'(FRAME);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] pix_cnt_q, pix_cnt_d;
  logic          vs_prev_q;
  logic          pop_q;
  logic          de_q, hs_q, vs_q;

  logic          fifo_full, fifo_empty;
  logic [15:0]   rd_data;
  logic          vs_rise, in_frame, need_pop;
  logic          pop, uf, wr_en;
  rgb888_t       px;

  scanout_fifo #(.AW(FIFO_AW), .DW(16)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (uf),
    .wr_en   (wr_en),
    .wr_data (in_data),
    .rd_en   (pop),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    in_ready  = (state_q == ST_WAIT_SRC) | ~fifo_full;
    vs_rise   = vid_vs & ~vs_prev_q;
    in_frame  = pix_cnt_q < FRAME_C;
    need_pop  = (state_q == ST_RUN) & vid_de & in_frame;
    pop       = need_pop & ~fifo_empty;
    uf        = need_pop & fifo_empty;
    // While hunting for sync, only the frame-start word is kept.
    wr_en     = in_valid & in_ready &
                ((state_q != ST_WAIT_SRC) | in_vs);
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    unique case (state_q)
      ST_WAIT_SRC: begin
        if (in_valid && in_vs) state_d = ST_WAIT_DISP;
      end
      ST_WAIT_DISP: begin
        if (vs_rise) begin
          state_d   = ST_RUN;
          pix_cnt_d = '0;
        end
      end
      ST_RUN: begin
        if (uf) state_d = ST_WAIT_SRC;
        if (vs_rise) pix_cnt_d = '0;
        else if (vid_de && in_frame) pix_cnt_d = pix_cnt_q + 1'b1;
      end
      default: state_d = ST_WAIT_SRC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_WAIT_SRC;
      pix_cnt_q <= '0;
      vs_prev_q <= 1'b0;
      pop_q     <= 1'b0;
      de_q      <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      vs_prev_q <= vid_vs;
      pop_q     <= pop;
      de_q      <= vid_de;
      hs_q      <= vid_hs;
      vs_q      <= vid_vs;
    end
  end

  assign px        = pop_q ? expand565(rd_data) : '0;
  assign out_r     = px.r;
  assign out_g     = px.g;
  assign out_b     = px.b;
  assign out_de    = de_q;
  assign out_hs    = hs_q;
  assign out_vs    = vs_q;
  assign underflow = uf;
  assign locked    = (state_q == ST_RUN);

endmodule

// File: tb/tb_frame_scanout.sv
// Scoreboard bench for frame_scanout: stimulus pushes expected
// pixels, a negedge monitor pops them on every out_de cycle.
module tb_frame_scanout;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid, in_vs, in_ready;
  logic        vid_de, vid_hs, vid_vs;
  logic        out_de, out_hs, out_vs;
  logic [7:0]  out_r, out_g, out_b;
  logic        underflow, locked;

  int checks   = 0;
  int failures = 0;
  logic [23:0] exp_q[$];

  frame_scanout #(.H_DISP(32), .V_DISP(24), .FIFO_AW(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_vs     (in_vs),
    .in_ready  (in_ready),
    .vid_de    (vid_de),
    .vid_hs    (vid_hs),
    .vid_vs    (vid_vs),
    .out_de    (out_de),
    .out_hs    (out_hs),
    .out_vs    (out_vs),
    .out_r     (out_r),
    .out_g     (out_g),
    .out_b     (out_b),
    .underflow (underflow),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] exp565(input logic [15:0] p);
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    r = p[15:11];
    g = p[10:5];
    b = p[4:0];
    return {r, r[4:2], g, g[5:4], b, b[4:2]};
  endfunction

  function automatic logic [15:0] w_bp(input int i);
    return 16'(i * 16'h0843 + 16'h0101);
  endfunction

  function automatic logic [15:0] w_fr(input int i);
    return 16'(i * 40503 + 7);
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_de) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pixel: got %06h with no expected pixel",
                 {out_r, out_g, out_b});
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        if ({out_r, out_g, out_b} !== e) begin
          failures++;
          $display("FAIL pixel: got %06h expected %06h",
                   {out_r, out_g, out_b}, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] d, input logic vs);
    in_valid = 1'b1;
    in_data  = d;
    in_vs    = vs;
    step();
    in_valid = 1'b0;
    in_vs    = 1'b0;
  endtask

  task automatic vs_pulse();
    vid_vs = 1'b1;
    vid_hs = 1'b1;
    step();
    vid_vs = 1'b0;
    vid_hs = 1'b0;
    check("out_vs_delay", out_vs, 1);
    check("out_hs_delay", out_hs, 1);
    check("locked_after_vs", locked, 1);
  endtask

  task automatic de_cycle(input logic [23:0] e);
    vid_de = 1'b1;
    exp_q.push_back(e);
    step();
    vid_de = 1'b0;
  endtask

  initial begin
    int acc, wc;
    rst = 1'b1;
    in_data = '0; in_valid = 0; in_vs = 0;
    vid_de = 0; vid_hs = 0; vid_vs = 0;
    repeat (3) step();
    check("rst_in_ready", in_ready, 1);
    check("rst_out", {out_de, out_hs, out_vs, out_r, out_g, out_b}, 0);
    check("rst_locked", locked, 0);
    check("rst_underflow", underflow, 0);
    rst = 1'b0;
    step();

    // Words before the frame marker must be dropped.
    for (int i = 0; i < 5; i++) begin
      wr(16'h1234 + 16'(i), 1'b0);
      check("wait_src_ready", in_ready, 1);
    end
    wr(16'hF800, 1'b1);
    check("wait_disp_unlocked", locked, 0);
    vs_pulse();
    de_cycle(24'hFF0000);
    step();

    // Expansion of mid-scale and full-scale channels.
    wr(16'h8410, 1'b0);
    wr(16'h07E0, 1'b0);
    wr(16'h001F, 1'b0);
    de_cycle(24'h848284);
    de_cycle(24'h00FF00);
    de_cycle(24'h0000FF);
    step();

    // Backpressure: fill a 64-deep FIFO with no DE.
    acc = 0;
    in_valid = 1'b1;
    in_data  = w_bp(0);
    for (int n = 0; n < 100; n++) begin
      #2;
      if (!in_ready) break;
      acc++;
      step();
      in_data = w_bp(acc);
    end
    check("bp_accepted", acc, 64);
    for (int n = 0; n < 3; n++) begin
      step();
      check("bp_ready_low", in_ready, 0);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 64; i++) de_cycle(exp565(w_bp(i)));
    step();
    check("bp_ready_back", in_ready, 1);

    // Frame limit: 769 DE cycles, the last must be blank.
    vs_pulse();
    for (int i = 0; i < 4; i++) wr(w_fr(i), 1'b0);
    wc = 4;
    for (int i = 0; i < 769; i++) begin
      vid_de = 1'b1;
      if (wc < 768) begin
        in_valid = 1'b1;
        in_data  = w_fr(wc);
        in_vs    = (wc == 5);
        wc++;
      end else begin
        in_valid = 1'b0;
        in_vs    = 1'b0;
      end
      exp_q.push_back(i < 768 ? exp565(w_fr(i)) : 24'h0);
      #2;
      check("frame_no_underflow", underflow, 0);
      step();
    end
    vid_de = 0; in_valid = 0; in_vs = 0;
    step();
    check("frame_still_locked", locked, 1);

    // Underflow: two words, three DE cycles.
    wr(16'hABCD, 1'b0);
    wr(16'h5555, 1'b0);
    vs_pulse();
    vid_de = 1'b1;
    exp_q.push_back(exp565(16'hABCD));
    #2 check("uf_pix0", underflow, 0);
    step();
    exp_q.push_back(exp565(16'h5555));
    #2 check("uf_pix1", underflow, 0);
    step();
    exp_q.push_back(24'h0);
    in_valid = 1'b1;
    in_data  = 16'h1111;
    #2 check("uf_pulse", underflow, 1);
    step();
    vid_de = 0; in_valid = 0;
    check("uf_pulse_end", underflow, 0);
    check("uf_unlocked", locked, 0);
    check("uf_in_ready", in_ready, 1);

    // Relock: stale or same-cycle words must not reappear.
    wr(16'hFFFF, 1'b1);
    vs_pulse();
    de_cycle(24'hFFFFFF);
    repeat (3) step();
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
